sub_serial_8: RTL and testbench
===============================

SUB_SERIAL_8 -- requirements
Module: sub_serial_8

Interface
REQ-001 SHALL have no parameters; width fixed at 8 (WIDTH=8 in shared package).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 in1  input  8  minuend.
REQ-007 in2  input  8  subtrahend.
REQ-008 bin  input  1  borrow-in, for multi-byte chaining.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 diff  output  8  in1 - in2 - bin, modulo 256.
REQ-012 bout  output  1  borrow-out; 1 when in1 < in2 + bin (unsigned).
REQ-013 zero  output  1  1 when diff == 8'h00.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; in_valid=1 SHALL latch in1, in2, carry=~bin, clear bit counter to 0, and go to RUN.
REQ-016 RUN: in_ready=0; each cycle SHALL compute one result bit, LSB first, as a_i + ~b_i + carry (one full-adder step), shift it into the diff register, and update carry.
REQ-017 Bit counter 3-bit; RUN SHALL last exactly 8 cycles and go to DONE after count 7 (counter wrap 7->0 is the exit condition).
REQ-018 DONE: out_valid=1; bout SHALL equal ~final carry; diff, bout, zero SHALL remain stable until handshake.
REQ-019 DONE with out_ready=1 SHALL go to IDLE the next cycle; out_ready=0 SHALL hold DONE indefinitely.
REQ-020 Latency: request accepted in cycle T -> out_valid high in cycle T+9.
REQ-021 in_valid during RUN/DONE SHALL be ignored (not latched, no queuing).
REQ-022 Throughput: one result per 10 cycles minimum (accept, 8 RUN, DONE with out_ready=1).
REQ-023 in_ready and out_valid SHALL be registered-state decodes, never combinationally dependent on in_valid/out_ready.
REQ-024 out_valid and in_ready SHALL never be high in the same cycle.
REQ-025 diff/zero/bout outside DONE: undefined contents permitted, but no X after reset.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, in_ready=1 after release, out_valid=0, diff=8'h00, bout=0, zero=0, counter=0, carry=0.
REQ-027 Reset during RUN or DONE SHALL abort the operation; no out_valid for the aborted request.
REQ-028 Reset SHALL dominate in_valid in the same cycle (request not accepted).

Structure
REQ-029 Shared package SHALL hold WIDTH=8, CNT_W=3, and the state enum type (IDLE, RUN, DONE).
REQ-030 Per-bit arithmetic SHALL use one instance of the existing single-bit full adder FA_1 (in1, in2, cin, sum, cout), driven with in2 bit inverted.
REQ-031 Operand/result shift registers, counter, and FSM SHALL live in sub_serial_8; no other sub-modules.

Verification
REQ-032 in1=0x05, in2=0x03, bin=0 -> after 9 cycles diff=0x02, bout=0, zero=0.
REQ-033 in1=0x03, in2=0x05, bin=0 -> diff=0xFE, bout=1, zero=0; then in1=0x00, in2=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-034 in1=0x80, in2=0x80, bin=0 -> diff=0x00, bout=0, zero=1.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; in_valid pulsed meanwhile not accepted; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n=0 at RUN cycle 4 -> next cycle IDLE, out_valid=0, diff=0x00; new request 0x10-0x01 -> diff=0x0F, bout=0.
REQ-037 Multi-byte: 16-bit 0x0100-0x0001 as low byte (0x00-0x01, bin=0 -> 0xFF, bout=1) then high byte (0x01-0x00, bin=1 -> 0x00, bout=0, zero=1).

Source files
------------

// File: rtl/sub_serial_8_pkg.sv
// Shared widths and FSM state type for the bit-serial 8-bit subtractor.
package sub_serial_8_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/FA_1.sv
// Single-bit full adder.
module FA_1 (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = in1 ^ in2 ^ cin;
    assign cout = (in1 & in2) | (cin & (in1 ^ in2));

endmodule

// File: rtl/sub_serial_8.sv
// Bit-serial 8-bit subtractor: diff = in1 - in2 - bin, one bit per cycle, LSB first,
// computed as in1 + ~in2 + ~bin through a single full adder.
module sub_serial_8
    import sub_serial_8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry;
    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   diff_nxt;

    FA_1 u_fa (
        .in1  (a_q[0]),
        .in2  (~b_q[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New result bit enters at the MSB so the LSB-first stream lands in place after 8 shifts.
    assign diff_nxt = {fa_sum, diff[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        carry    <= ~bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    diff  <= diff_nxt;
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    // Last bit: counter is about to wrap 7 -> 0.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bout      <= ~fa_cout;
                        zero      <= (diff_nxt == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial_8.sv
// Scoreboard bench for sub_serial_8: directed corner cases plus randomized traffic with backpressure.
module tb_sub_serial_8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       zero;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_ov = 1'b0;

    sub_serial_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: plain integer subtraction.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        exp_t e;
        int   r;
        r   = int'(a) - int'(b) - int'(bi);
        e.d = 8'(r);
        e.b = (int'(a) < int'(b) + int'(bi));
        e.z = (e.d == 8'h00);
        return e;
    endfunction

    // Sampler/monitor: runs mid low-phase, predicting what the next rising edge does.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (in_ready === 1'b1 && out_valid === 1'b1)
            chk("ready_valid_exclusive", 1, 0);
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("diff", 32'(diff), 32'(exp_q[0].d));
                chk("bout", 32'(bout), 32'(exp_q[0].b));
                chk("zero", 32'(zero), 32'(exp_q[0].z));
                if (!prev_ov) chk("latency", 32'(cyc - acc_cyc), 32'd9);
                if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
        prev_ov = (out_valid === 1'b1);
        if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
            exp_q.push_back(model(in1, in2, bin));
            acc_cyc = cyc;
        end
        if (rst_n !== 1'b1) exp_q.delete();
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi, input int hold);
        int n;
        wait_ready();
        in1 = a; in2 = b; bin = bi; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        in1 = 8'($urandom); in2 = 8'($urandom); bin = 1'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("out_valid_timeout", 0, 1);
            out_ready = 1'b1;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in1 = 8'($urandom); in2 = 8'($urandom);
            @(negedge clk);
            chk("in_ready_low_in_done", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_handshake", {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in1 = 8'h55; in2 = 8'h11; bin = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_outputs", {22'd0, diff, bout, zero}, 32'd0);

        send(8'h05, 8'h03, 1'b0, 0);
        send(8'h03, 8'h05, 1'b0, 0);
        send(8'h00, 8'h00, 1'b1, 0);
        send(8'h80, 8'h80, 1'b0, 0);
        send(8'hA7, 8'h3C, 1'b1, 5);

        // Abort in the middle of RUN.
        wait_ready();
        in1 = 8'h77; in2 = 8'h01; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_diff", 32'(diff), 0);
        repeat (12) @(negedge clk);
        send(8'h10, 8'h01, 1'b0, 0);

        // 16-bit 0x0100 - 0x0001 as two chained bytes.
        send(8'h00, 8'h01, 1'b0, 0);
        send(8'h01, 8'h00, 1'b1, 0);

        for (int t = 0; t < 40; t++)
            send(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        send(8'hFF, 8'hFF, 1'b1, 1);
        send(8'h00, 8'hFF, 1'b1, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
